// File: rtl/coreahbltoaxi_rdch_ctrl.sv
// Read-channel FIFO controller for the AHB-Lite to AXI bridge.
// This block accepts AXI R beats into an external 16 x 32 RAM.
// It generates the RAM strobes and addresses.
// It keeps a last/error flag for each entry.
// It counts how many complete bursts are buffered, so the AHB side can
// start returning data once a whole burst is available.
module coreahbltoaxi_rdch_ctrl #(
    parameter int RAM_AWIDTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  RVALID,
    input  logic                  RLAST,
    input  logic [1:0]            RRESP,
    output logic                  RREADY,
    input  logic                  rd_req,
    input  logic                  flush,
    output logic                  We1,
    output logic [RAM_AWIDTH-1:0] WAddr,
    output logic                  Wfull,
    output logic                  Re1,
    output logic [RAM_AWIDTH-1:0] RAddr,
    output logic                  Rempty,
    output logic                  rdata_valid,
    output logic                  rd_last,
    output logic                  rd_err,
    output logic [RAM_AWIDTH:0]   level,
    output logic [RAM_AWIDTH:0]   bursts
);

    localparam int FDEPTH = 2 ** RAM_AWIDTH;
    localparam logic [RAM_AWIDTH:0] ZERO_W = {(RAM_AWIDTH + 1){1'b0}};
    localparam logic [RAM_AWIDTH:0] ONE_W  = {{RAM_AWIDTH{1'b0}}, 1'b1};
    localparam logic [RAM_AWIDTH:0] FULL_W = {1'b1, {RAM_AWIDTH{1'b0}}};

    logic [RAM_AWIDTH:0]        wptr_q, wptr_d;
    logic [RAM_AWIDTH:0]        rptr_q, rptr_d;
    logic [RAM_AWIDTH:0]        level_q, level_d;
    logic [RAM_AWIDTH:0]        bursts_q, bursts_d;
    // Each entry holds {last, err}.
    logic [FDEPTH-1:0][1:0]     flag_q, flag_d;
    logic                       rdv_q, rdv_d;
    logic [1:0]                 rflag_q, rflag_d;

    logic                       push_s, pop_s, push_last_s, pop_last_s;
    logic                       wfull_s, rempty_s, rready_s;

    // Status flags and push/pop qualification from registered state.
    always_comb begin
        wfull_s     = (level_q == FULL_W);
        rempty_s    = (level_q == ZERO_W);
        rready_s    = ~wfull_s & ~flush;
        push_s      = RVALID & rready_s;
        pop_s       = rd_req & ~rempty_s & ~flush;
        push_last_s = push_s & RLAST;
        pop_last_s  = pop_s & flag_q[rptr_q[RAM_AWIDTH-1:0]][1];
    end

    // Next-state for pointers, counters, flag array and read-return flags.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        bursts_d = bursts_q;
        flag_d   = flag_q;
        rdv_d    = pop_s;
        rflag_d  = pop_s ? flag_q[rptr_q[RAM_AWIDTH-1:0]] : 2'b00;
        if (flush) begin
            wptr_d   = ZERO_W;
            rptr_d   = ZERO_W;
            level_d  = ZERO_W;
            bursts_d = ZERO_W;
            flag_d   = '0;
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + ONE_W;
                flag_d[wptr_q[RAM_AWIDTH-1:0]] = {RLAST, RRESP[1]};
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + ONE_W;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + ONE_W;
                2'b01:   level_d = level_q - ONE_W;
                default: level_d = level_q;
            endcase
            case ({push_last_s, pop_last_s})
                2'b10:   bursts_d = bursts_q + ONE_W;
                2'b01:   bursts_d = bursts_q - ONE_W;
                default: bursts_d = bursts_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            wptr_q   <= ZERO_W;
            rptr_q   <= ZERO_W;
            level_q  <= ZERO_W;
            bursts_q <= ZERO_W;
            flag_q   <= '0;
            rdv_q    <= 1'b0;
            rflag_q  <= 2'b00;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            bursts_q <= bursts_d;
            flag_q   <= flag_d;
            rdv_q    <= rdv_d;
            rflag_q  <= rflag_d;
        end
    end

    // Drive outputs.
    always_comb begin
        RREADY      = rready_s;
        We1         = push_s;
        Re1         = pop_s;
        WAddr       = wptr_q[RAM_AWIDTH-1:0];
        RAddr       = rptr_q[RAM_AWIDTH-1:0];
        Wfull       = wfull_s;
        Rempty      = rempty_s;
        rdata_valid = rdv_q;
        rd_last     = rflag_q[1];
        rd_err      = rflag_q[0];
        level       = level_q;
        bursts      = bursts_q;
    end

endmodule

// File: tb/tb_coreahbltoaxi_rdch_ctrl.sv
// Directed bench for coreahbltoaxi_rdch_ctrl.
// The bench includes a small registered RAM model so that data order can be observed.
module tb_coreahbltoaxi_rdch_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        RVALID, RLAST, rd_req, flush;
    logic [1:0]  RRESP;
    logic        RREADY, We1, Wfull, Re1, Rempty, rdata_valid, rd_last, rd_err;
    logic [3:0]  WAddr, RAddr;
    logic [4:0]  level, bursts;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;
    int wr_id, rd_id, wrapw, wrapr;
    logic [3:0] prev_w, prev_r;

    coreahbltoaxi_rdch_ctrl #(.RAM_AWIDTH(4)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .RVALID(RVALID), .RLAST(RLAST),
        .RRESP(RRESP), .RREADY(RREADY), .rd_req(rd_req), .flush(flush),
        .We1(We1), .WAddr(WAddr), .Wfull(Wfull), .Re1(Re1), .RAddr(RAddr),
        .Rempty(Rempty), .rdata_valid(rdata_valid), .rd_last(rd_last),
        .rd_err(rd_err), .level(level), .bursts(bursts)
    );

    always #5 HCLK = ~HCLK;

    // RAM model: registered read data, zero when no read strobe.
    always @(posedge HCLK) begin
        if (We1) mem[WAddr] <= wdata;
        rdata <= Re1 ? mem[RAddr] : 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETN = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        rd_req = 1'b0; flush = 1'b0; wdata = 32'd0;
        wr_id = 0; rd_id = 0; wrapw = 0; wrapr = 0;

        // Reset for three cycles
        repeat (3) tick();
        chk("rst_level", level, 0);
        chk("rst_bursts", bursts, 0);
        chk("rst_rempty", Rempty, 1);
        chk("rst_wfull", Wfull, 0);
        chk("rst_rready", RREADY, 1);
        chk("rst_rdv", rdata_valid, 0);
        HRESETN = 1'b1;
        tick();

        // Sixteen pushes with RLAST on beats 3, 7, 11, 15
        for (int i = 0; i < 16; i++) begin
            RVALID = 1'b1; wdata = i; RLAST = (i % 4 == 3); RRESP = 2'b00;
            #1;
            chk("fill_we1", We1, 1);
            chk("fill_waddr", WAddr, i);
            tick();
        end
        chk("full_level", level, 16);
        chk("full_bursts", bursts, 4);
        chk("full_wfull", Wfull, 1);
        chk("full_rready", RREADY, 0);
        // A 17th beat is offered and must not be accepted.
        wdata = 32'h99; RLAST = 1'b0;
        #1;
        chk("full_we1_blocked", We1, 0);
        tick();
        chk("full_waddr_hold", WAddr, 0);
        chk("full_level_hold", level, 16);
        RVALID = 1'b0;

        // Drain all sixteen entries
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_re1", Re1, 1);
            chk("drain_raddr", RAddr, i);
            tick();
            chk("drain_rdv", rdata_valid, 1);
            chk("drain_rdata", rdata, i);
            chk("drain_last", rd_last, (i % 4 == 3));
            chk("drain_err", rd_err, 0);
            chk("drain_bursts", bursts, 4 - (i + 1) / 4);
        end
        chk("drain_rempty", Rempty, 1);
        #1;
        chk("empty_re1", Re1, 0);
        tick();
        chk("empty_rdv", rdata_valid, 0);
        rd_req = 1'b0;

        // Fill to five, then push and pop together for forty cycles
        wr_id = 256; rd_id = 256;
        for (int i = 0; i < 5; i++) begin
            RVALID = 1'b1; wdata = wr_id; wr_id++;
            tick();
        end
        chk("steady_pre_level", level, 5);
        rd_req = 1'b1;
        prev_w = WAddr; prev_r = RAddr;
        for (int i = 0; i < 40; i++) begin
            wdata = wr_id; wr_id++;
            #1;
            if (prev_w == 4'd15 && WAddr == 4'd0) wrapw++;
            if (prev_r == 4'd15 && RAddr == 4'd0) wrapr++;
            prev_w = WAddr; prev_r = RAddr;
            chk("steady_both", {We1, Re1}, 2'b11);
            tick();
            chk("steady_level", level, 5);
            chk("steady_rdata", rdata, rd_id); rd_id++;
        end
        chk("steady_wrapw", (wrapw >= 2), 1);
        chk("steady_wrapr", (wrapr >= 2), 1);
        RVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("steady_drain_rdata", rdata, rd_id); rd_id++;
        end
        chk("steady_empty", Rempty, 1);
        rd_req = 1'b0;

        // Four-beat burst with an error on beat 2
        for (int i = 0; i < 4; i++) begin
            RVALID = 1'b1; wdata = 32'hE0 + i;
            RRESP = (i == 1) ? 2'b10 : 2'b00;
            RLAST = (i == 3);
            tick();
        end
        RVALID = 1'b0; RRESP = 2'b00; RLAST = 1'b0;
        chk("err_bursts", bursts, 1);
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_rd_err", rd_err, (i == 1));
            chk("err_rd_last", rd_last, (i == 3));
            chk("err_rdata", rdata, 32'hE0 + i);
        end
        rd_req = 1'b0;
        chk("err_bursts_done", bursts, 0);

        // Level 7 with one burst, then flush while RVALID and rd_req are both high
        for (int i = 0; i < 7; i++) begin
            RVALID = 1'b1; wdata = i; RLAST = (i == 6);
            tick();
        end
        RLAST = 1'b0;
        chk("pre_flush_level", level, 7);
        chk("pre_flush_bursts", bursts, 1);
        flush = 1'b1; rd_req = 1'b1;
        #1;
        chk("flush_we1", We1, 0);
        chk("flush_re1", Re1, 0);
        tick();
        flush = 1'b0; RVALID = 1'b0; rd_req = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_bursts", bursts, 0);
        chk("flush_rempty", Rempty, 1);
        chk("flush_rdv", rdata_valid, 0);

        // Reset in the middle of a burst discards all stored state.
        for (int i = 0; i < 3; i++) begin
            RVALID = 1'b1; wdata = i;
            tick();
        end
        RVALID = 1'b0;
        chk("mid_level", level, 3);
        HRESETN = 1'b0;
        #1;
        chk("async_rst_level", level, 0);
        chk("async_rst_rempty", Rempty, 1);
        HRESETN = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coreahbltoaxi_rdch_ctrl.md
# coreahbltoaxi_rdch_ctrl

Single-clock FIFO controller for the 16 x 32 read-channel RAM of the AHB-Lite to AXI bridge. It accepts AXI R-channel beats, generates the RAM write and read strobes and addresses, and tracks fill level and empty/full status. It also keeps per-entry last/error flags and a count of complete bursts, so the AHB-side sequencer can start returning HRDATA once a whole burst is buffered. It sits between the AXI R interface and the RAM; Rdata is taken directly from the RAM.

## Interface
- RAM_AWIDTH, 4: RAM address width; FDEPTH = 2**RAM_AWIDTH (16 entries).
- HCLK  in  1  bridge clock; also drives the RAM WCLK and RCLK.
- HRESETN  in  1  asynchronous, active-low reset.
- RVALID  in  1  AXI read beat offered.
- RLAST  in  1  beat is last of its burst.
- RRESP  in  2  AXI response; bit 1 set = SLVERR/DECERR.
- RREADY  out  1  beat accepted this cycle when high with RVALID.
- rd_req  in  1  AHB side requests one word.
- flush  in  1  synchronous clear of all FIFO state.
- We1  out  1  RAM write strobe.
- WAddr  out  RAM_AWIDTH  RAM write address.
- Wfull  out  1  FIFO full; also RAM write gate.
- Re1  out  1  RAM read strobe.
- RAddr  out  RAM_AWIDTH  RAM read address.
- Rempty  out  1  FIFO empty.
- rdata_valid  out  1  RAM Rdata holds a popped word this cycle.
- rd_last  out  1  flag of the word qualified by rdata_valid: it ended a burst.
- rd_err  out  1  flag of the word qualified by rdata_valid: it carried an error response.
- level  out  RAM_AWIDTH+1  number of stored words, 0..FDEPTH.
- bursts  out  RAM_AWIDTH+1  number of complete bursts stored.

## Operation
- Pointers wptr and rptr are RAM_AWIDTH+1 bits. They wrap modulo 2*FDEPTH. WAddr and RAddr are their low RAM_AWIDTH bits.
- Flags:
  - Wfull = (level == FDEPTH).
  - Rempty = (level == 0).
  - Both are combinational from registered state.
- Push:
  - RREADY = ~Wfull & ~flush.
  - push = RVALID & RREADY, and We1 = push.
  - On push, wptr increments and flag[WAddr] <= {RLAST, RRESP[1]}.
- Pop:
  - pop = rd_req & ~Rempty & ~flush, and Re1 = pop.
  - On pop, rptr increments.
- Level updates:
  - level: +1 on push only, -1 on pop only, unchanged on both or neither.
  - bursts: +1 on push with RLAST; -1 on pop of an entry whose last flag is set; unchanged if both occur.
- Read return: rdata_valid, rd_last and rd_err are registered.
  - rdata_valid <= pop.
  - {rd_last, rd_err} <= pop ? flag[RAddr] : 2'b00.
  - These outputs line up with the RAM's registered Rdata, which the RAM zeroes when Re1 is low.
- Boundary behaviour:
  - Push while full: impossible (RREADY low). The beat stays held by the AXI slave.
  - Pop while empty: Re1 stays 0 and rdata_valid is 0 on the next cycle.
  - Simultaneous push and pop at full: only the pop occurs (RREADY low). At empty: only the push occurs, with no fall-through.
- Flush: while flush = 1, We1 = Re1 = 0. On the next edge, wptr, rptr, level and bursts go to 0 and the flags are cleared. rdata_valid is 0 on the following cycle. RAM contents are not cleared.
- Reset: asynchronous, HRESETN low.
  - Registered state goes to 0: pointers, level, bursts, flag array, rdata_valid, rd_last, rd_err.
  - Combinational outputs during reset: Rempty = 1, Wfull = 0, RREADY = 1 (while flush = 0), We1 = Re1 = 0 (while RVALID / rd_req are not driving them).
  - Reset mid-burst discards all stored state.

## Timing
- Push at edge k: level, bursts and Rempty update after edge k. The word is poppable at edge k+1 at the earliest.
- Pop at edge k: Rdata, rdata_valid, rd_last and rd_err are valid in cycle k+1 (1-cycle latency).
- Throughput is one push and one pop per cycle.
- Wfull asserts in the cycle after the 16th unmatched push. RREADY drops in that same cycle.

## Test plan
- Reset with HRESETN = 0 for 3 cycles -> level = 0, bursts = 0, Rempty = 1, Wfull = 0, RREADY = 1, rdata_valid = 0.
- 16 pushes of data 0x00..0x0F with RLAST on beats 3, 7, 11, 15, no pops -> level = 16, bursts = 4, Wfull = 1, RREADY = 0. A 17th beat held by RVALID is not accepted and WAddr stays 0.
- Pop all 16 with rd_req held high -> rdata_valid is high one cycle after each Re1. Rdata reads 0x00..0x0F in order. rd_last is set on words 3, 7, 11, 15 only. bursts steps 4 -> 0. Rempty = 1 after the last pop, and a 17th rd_req gives Re1 = 0.
- Fill to level 5, then push and pop simultaneously for 40 cycles -> level stays 5. WAddr and RAddr wrap 15 -> 0 at least twice. Data order is preserved.
- Burst of 4 beats with RRESP = 2'b10 on beat 2 only -> on pop, rd_err = 1 only on that word, and rd_last = 1 on beat 4.
- Level 7 with bursts = 1, then assert flush for 1 cycle while RVALID = 1 and rd_req = 1 -> We1 = Re1 = 0 during flush. Next cycle level = 0, bursts = 0, Rempty = 1, and rdata_valid = 0.
